arbitro_tx: RTL and testbench

Message-level round-robin arbiter that shares the single UART transmitter between two character-stream requesters, e.g. the play analyser and the score/status reporter. It grants one requester at a time and sequences its message char by char: it loads each char, pulses `partida_tx`, waits for `pronto_tx`, then asks the requester to advance. The grant is held until the requester's last char completes or a watchdog timeout fires. It sits between the game control units and the UART tx datapath.

---
 rtl/arbitro_tx.sv | 143 ++++++++++++++
 tb/tb_arbitro_tx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_tx.sv
// Round-robin, message-level arbiter sharing one UART transmitter between two char streams.
// One char: carrega -> envia (start pulse) -> aguarda pronto (watchdog) -> advance or release.
module arbitro_tx #(
    parameter int DATA_W         = 7,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [DATA_W-1:0] i_dado0,
    input  logic [DATA_W-1:0] i_dado1,
    input  logic              i_ultimo0,
    input  logic              i_ultimo1,
    input  logic              i_pronto_tx,
    output logic              o_partida_tx,
    output logic [DATA_W-1:0] o_dado_tx,
    output logic              o_grant0,
    output logic              o_grant1,
    output logic              o_prox0,
    output logic              o_prox1,
    output logic              o_fim0,
    output logic              o_fim1,
    output logic              o_erro_timeout,
    output logic              o_ocupado
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        ENVIA,
        AGUARDA,
        AVANCA,
        FIM,
        ABORTA
    } estado_t;

    estado_t           r_estado;
    estado_t           w_prox_estado;
    logic              r_dono;
    logic              r_ult_serv;
    logic              r_ultimo;
    logic [TW-1:0]     r_timer;
    logic [DATA_W-1:0] r_dado_tx;

    logic              w_dono_sel;
    logic              w_tempo_esgotado;
    logic [DATA_W-1:0] w_dado_dono;
    logic              w_ultimo_dono;

    // On a tie the requester that was not served last wins.
    assign w_dono_sel       = (i_req0 && i_req1) ? ~r_ult_serv : i_req1;
    assign w_tempo_esgotado = (r_timer == TMAX);
    assign w_dado_dono      = r_dono ? i_dado1 : i_dado0;
    assign w_ultimo_dono    = r_dono ? i_ultimo1 : i_ultimo0;
    assign o_dado_tx        = r_dado_tx;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado  = r_estado;
        o_partida_tx   = 1'b0;
        o_prox0        = 1'b0;
        o_prox1        = 1'b0;
        o_fim0         = 1'b0;
        o_fim1         = 1'b0;
        o_erro_timeout = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (i_req0 || i_req1) begin
                    w_prox_estado = CARREGA;
                end
            end
            CARREGA: w_prox_estado = ENVIA;
            ENVIA: begin
                o_partida_tx  = 1'b1;
                w_prox_estado = AGUARDA;
            end
            AGUARDA: begin
                // pronto on the final watchdog cycle still counts as success
                if (i_pronto_tx) begin
                    w_prox_estado = r_ultimo ? FIM : AVANCA;
                end else if (w_tempo_esgotado) begin
                    w_prox_estado = ABORTA;
                end
            end
            AVANCA: begin
                o_prox0       = ~r_dono;
                o_prox1       = r_dono;
                w_prox_estado = CARREGA;
            end
            FIM: begin
                o_fim0        = ~r_dono;
                o_fim1        = r_dono;
                w_prox_estado = OCIOSO;
            end
            ABORTA: begin
                o_erro_timeout = 1'b1;
                o_fim0         = ~r_dono;
                o_fim1         = r_dono;
                w_prox_estado  = OCIOSO;
            end
            default: w_prox_estado = OCIOSO;
        endcase
        o_ocupado = (r_estado != OCIOSO);
        o_grant0  = o_ocupado && !r_dono;
        o_grant1  = o_ocupado && r_dono;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dono     <= 1'b0;
            r_ult_serv <= 1'b1;
            r_ultimo   <= 1'b0;
            r_timer    <= '0;
            r_dado_tx  <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (i_req0 || i_req1) begin
                        r_dono <= w_dono_sel;
                    end
                end
                CARREGA: begin
                    r_dado_tx <= w_dado_dono;
                    r_ultimo  <= w_ultimo_dono;
                end
                ENVIA:       r_timer    <= '0;
                AGUARDA:     r_timer    <= r_timer + TW'(1);
                FIM, ABORTA: r_ult_serv <= r_dono;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_tx.sv
// Bench for arbitro_tx: cycle table, directed message scenarios and a randomized run
// checked against an event-scheduled reference model built from the timing rules.
module tb_arbitro_tx;
    localparam int TO = 16;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_req0 = 1'b0, i_req1 = 1'b0;
    logic [6:0] i_dado0 = '0, i_dado1 = '0;
    logic       i_ultimo0 = 1'b0, i_ultimo1 = 1'b0;
    logic       i_pronto_tx = 1'b0;
    logic       o_partida_tx;
    logic [6:0] o_dado_tx;
    logic       o_grant0, o_grant1, o_prox0, o_prox1, o_fim0, o_fim1;
    logic       o_erro_timeout, o_ocupado;

    arbitro_tx #(.DATA_W(7), .TIMEOUT_CYCLES(TO)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_dado0(i_dado0), .i_dado1(i_dado1),
        .i_ultimo0(i_ultimo0), .i_ultimo1(i_ultimo1),
        .i_pronto_tx(i_pronto_tx),
        .o_partida_tx(o_partida_tx), .o_dado_tx(o_dado_tx),
        .o_grant0(o_grant0), .o_grant1(o_grant1),
        .o_prox0(o_prox0), .o_prox1(o_prox1),
        .o_fim0(o_fim0), .o_fim1(o_fim1),
        .o_erro_timeout(o_erro_timeout), .o_ocupado(o_ocupado)
    );

    always #5 i_clock = ~i_clock;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic step();
        @(posedge i_clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- cycle table ----------------
    // fl = {partida, grant0, grant1, prox0, prox1, fim0, fim1, erro, ocupado}
    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [6:0] d0;
        logic       u0;
        logic [6:0] d1;
        logic       u1;
        logic       pr;
        logic [8:0] fl;
        logic [6:0] dtx;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                                input logic [6:0] d0, input logic u0,
                                input logic [6:0] d1, input logic u1, input logic pr,
                                input logic [8:0] fl, input logic [6:0] dtx);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.u0 = u0;
        v.d1 = d1; v.u1 = u1; v.pr = pr; v.fl = fl; v.dtx = dtx;
        return v;
    endfunction

    vec_t tab [23];

    // ---------------- reference model state ----------------
    logic [6:0] msg [2][8];
    int  len [2];
    int  idx [2];
    bit  active [2];
    int  lp [2];
    int  c_prox [2];
    int  c_fim [2];
    int  own, last_served, free_cyc;
    int  exp_start, exp_prox, exp_fim, exp_err, pronto_cyc;
    int  fixed_lat = 0;
    bit  rnd = 1'b0;
    int  c_part, c_err, g0_first, g1_first, err_cyc;

    task automatic set_msg(input int r, input int n, input logic [6:0] c0,
                           input logic [6:0] c1, input logic [6:0] c2);
        len[r] = n;
        msg[r][0] = c0; msg[r][1] = c1; msg[r][2] = c2;
        idx[r] = 0;
        active[r] = 1'b1;
    endtask

    task automatic new_msg(input int r);
        len[r] = $urandom_range(4, 1);
        for (int k = 0; k < len[r]; k++) msg[r][k] = 7'($urandom_range(127, 0));
        idx[r] = 0;
        active[r] = 1'b1;
    endtask

    task automatic drive();
        if (rnd) begin
            for (int r = 0; r < 2; r++)
                if (!active[r] && $urandom_range(3, 0) == 0) new_msg(r);
        end
        // spurious pronto only while idle, where it must be ignored
        i_pronto_tx = (cyc == pronto_cyc) || (rnd && own < 0 && $urandom_range(7, 0) == 0);
        if (cyc == pronto_cyc && own >= 0) lp[own] = cyc;
        // the owner may drop req mid-message; that must not end it
        i_req0 = active[0] && !(rnd && own == 0 && $urandom_range(1, 0) == 0);
        i_req1 = active[1] && !(rnd && own == 1 && $urandom_range(1, 0) == 0);
        i_dado0 = msg[0][idx[0]];
        i_ultimo0 = (idx[0] == len[0] - 1);
        i_dado1 = msg[1][idx[1]];
        i_ultimo1 = (idx[1] == len[1] - 1);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_req0 = 1'b0; i_req1 = 1'b0; i_pronto_tx = 1'b0;
        step();
        i_reset = 1'b0;
        chk("reset_outputs",
            {o_partida_tx, o_grant0, o_grant1, o_prox0, o_prox1, o_fim0, o_fim1,
             o_erro_timeout, o_ocupado, o_dado_tx}, 32'd0);
        own = -1; last_served = 1; free_cyc = cyc;
        exp_start = -1; exp_prox = -1; exp_fim = -1; exp_err = -1; pronto_cyc = -1;
        for (int r = 0; r < 2; r++) begin
            active[r] = 1'b0; idx[r] = 0; len[r] = 0; lp[r] = -1;
            c_prox[r] = 0; c_fim[r] = 0;
        end
        c_part = 0; c_err = 0; g0_first = -1; g1_first = -1; err_cyc = -1;
    endtask

    task automatic tick();
        logic [8:0] expv, actv;
        bit pr0, pr1;
        int lat;
        pr0 = i_req0;
        pr1 = i_req1;
        step();
        // a req seen during an idle cycle is owned from the next cycle
        if (own < 0 && (cyc - 1) >= free_cyc && (pr0 || pr1)) begin
            own = (pr0 && pr1) ? (last_served == 1 ? 0 : 1) : (pr1 ? 1 : 0);
            exp_start = cyc + 1;
        end
        expv = {cyc == exp_start, own == 0 && cyc == exp_prox, own == 1 && cyc == exp_prox,
                own == 0 && cyc == exp_fim, own == 1 && cyc == exp_fim, cyc == exp_err,
                own == 0, own == 1, own >= 0};
        actv = {o_partida_tx, o_prox0, o_prox1, o_fim0, o_fim1, o_erro_timeout,
                o_grant0, o_grant1, o_ocupado};
        chk($sformatf("cycle%0d_outputs", cyc), 32'(actv), 32'(expv));
        c_part += int'(o_partida_tx);
        c_prox[0] += int'(o_prox0); c_prox[1] += int'(o_prox1);
        c_fim[0] += int'(o_fim0); c_fim[1] += int'(o_fim1);
        c_err += int'(o_erro_timeout);
        if (o_erro_timeout) err_cyc = cyc;
        if (o_grant0 && g0_first < 0) g0_first = cyc;
        if (o_grant1 && g1_first < 0) g1_first = cyc;
        if (cyc == exp_start && own >= 0) begin
            chk($sformatf("cycle%0d_dado_tx", cyc), 32'(o_dado_tx), 32'(msg[own][idx[own]]));
            lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(20, 1);
            if (lat <= TO) begin
                pronto_cyc = cyc + lat;
                if (idx[own] == len[own] - 1) exp_fim = cyc + lat + 1;
                else exp_prox = cyc + lat + 1;
            end else begin
                exp_err = cyc + TO + 1;
                exp_fim = cyc + TO + 1;
            end
        end
        if (cyc == exp_prox && own >= 0) begin
            idx[own]++;
            exp_start = cyc + 2;
        end
        if (cyc == exp_fim && own >= 0) begin
            last_served = own;
            active[own] = 1'b0;
            own = -1;
            free_cyc = cyc + 1;
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int p_cyc, s_cyc;

    initial begin
        tab[0]  = mk(1, 0, 0, 7'h00, 0, 7'h00, 0, 0, 9'b000000000, 7'h00);
        tab[1]  = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 0, 9'b010000001, 7'h00);
        tab[2]  = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 0, 9'b110000001, 7'h30);
        tab[3]  = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 1, 9'b010000001, 7'h30);
        tab[4]  = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 1, 9'b010001001, 7'h30);
        tab[5]  = mk(0, 0, 1, 7'h30, 1, 7'h31, 1, 0, 9'b000000000, 7'h30);
        tab[6]  = mk(0, 0, 1, 7'h30, 1, 7'h31, 1, 0, 9'b001000001, 7'h30);
        tab[7]  = mk(0, 0, 1, 7'h30, 1, 7'h31, 1, 0, 9'b101000001, 7'h31);
        tab[8]  = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 0, 9'b001000001, 7'h31);
        tab[9]  = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 1, 9'b001000101, 7'h31);
        tab[10] = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 0, 9'b000000000, 7'h31);
        tab[11] = mk(0, 1, 1, 7'h30, 1, 7'h31, 1, 0, 9'b010000001, 7'h31);
        tab[12] = mk(1, 1, 1, 7'h30, 1, 7'h31, 1, 0, 9'b000000000, 7'h00);
        tab[13] = mk(0, 1, 0, 7'h41, 0, 7'h31, 1, 0, 9'b010000001, 7'h00);
        tab[14] = mk(0, 1, 0, 7'h41, 0, 7'h31, 1, 0, 9'b110000001, 7'h41);
        tab[15] = mk(0, 1, 0, 7'h41, 0, 7'h31, 1, 0, 9'b010000001, 7'h41);
        tab[16] = mk(0, 1, 0, 7'h41, 0, 7'h31, 1, 1, 9'b010100001, 7'h41);
        tab[17] = mk(0, 1, 0, 7'h42, 1, 7'h31, 1, 0, 9'b010000001, 7'h41);
        tab[18] = mk(0, 1, 0, 7'h42, 1, 7'h31, 1, 0, 9'b110000001, 7'h42);
        tab[19] = mk(0, 1, 0, 7'h42, 1, 7'h31, 1, 0, 9'b010000001, 7'h42);
        tab[20] = mk(0, 1, 0, 7'h42, 1, 7'h31, 1, 1, 9'b010001001, 7'h42);
        tab[21] = mk(0, 0, 0, 7'h42, 1, 7'h31, 1, 0, 9'b000000000, 7'h42);
        tab[22] = mk(0, 0, 0, 7'h42, 1, 7'h31, 1, 1, 9'b000000000, 7'h42);

        for (int i = 0; i < 23; i++) begin
            i_reset = tab[i].rst; i_req0 = tab[i].r0; i_req1 = tab[i].r1;
            i_dado0 = tab[i].d0; i_ultimo0 = tab[i].u0;
            i_dado1 = tab[i].d1; i_ultimo1 = tab[i].u1; i_pronto_tx = tab[i].pr;
            step();
            chk($sformatf("table_vec%0d", i),
                32'({o_partida_tx, o_grant0, o_grant1, o_prox0, o_prox1, o_fim0, o_fim1,
                     o_erro_timeout, o_ocupado, o_dado_tx}),
                32'({tab[i].fl, tab[i].dtx}));
        end

        // "ABC" from requester 0, UART answers 5 cycles after each start
        do_reset();
        fixed_lat = 5;
        set_msg(0, 3, 7'h41, 7'h42, 7'h43);
        drive();
        run(40);
        chk("abc_partidas", c_part, 3);
        chk("abc_prox0", c_prox[0], 2);
        chk("abc_fim0", c_fim[0], 1);
        chk("abc_grant1_seen", g1_first, -1);

        // req1 arrives during the second char of requester 0
        do_reset();
        set_msg(0, 3, 7'h41, 7'h42, 7'h43);
        drive();
        for (int k = 0; k < 40 && c_part < 2; k++) tick();
        chk("cont_wait_second_char", c_part, 2);
        set_msg(1, 1, 7'h5A, 7'h00, 7'h00);
        drive();
        run(40);
        // grant rises on the edge closing pronto+2, so it is first seen at pronto+3
        chk("cont_grant1_gap", g1_first - lp[0], 3);
        chk("cont_fim1", c_fim[1], 1);

        // tie after reset, then req1 alone, then another tie
        do_reset();
        fixed_lat = 3;
        set_msg(0, 1, 7'h11, 7'h00, 7'h00);
        set_msg(1, 1, 7'h22, 7'h00, 7'h00);
        drive();
        run(30);
        chk("tie1_first_is_0", g0_first < g1_first && g0_first >= 0, 1);
        set_msg(1, 1, 7'h23, 7'h00, 7'h00);
        drive();
        run(15);
        g0_first = -1; g1_first = -1;
        set_msg(0, 1, 7'h12, 7'h00, 7'h00);
        set_msg(1, 1, 7'h24, 7'h00, 7'h00);
        drive();
        s_cyc = cyc;
        run(30);
        chk("tie2_grant0_latency", g0_first - s_cyc, 1);
        chk("tie2_then_1", g1_first > g0_first, 1);

        // UART never answers: watchdog abort, then req1 accepted
        do_reset();
        fixed_lat = TO + 1;
        set_msg(0, 1, 7'h55, 7'h00, 7'h00);
        drive();
        for (int k = 0; k < 10 && c_part < 1; k++) tick();
        chk("to_wait_partida", c_part, 1);
        p_cyc = cyc;
        set_msg(1, 1, 7'h66, 7'h00, 7'h00);
        drive();
        run(20);
        chk("to_erro_latency", err_cyc - p_cyc, TO + 1);
        chk("to_erro_count", c_err, 1);
        chk("to_fim0", c_fim[0], 1);
        chk("to_grant1_gap", g1_first - err_cyc, 2);

        // pronto on the last watchdog cycle of each char
        do_reset();
        fixed_lat = TO;
        set_msg(0, 2, 7'h41, 7'h42, 7'h00);
        drive();
        run(50);
        chk("race_no_erro", c_err, 0);
        chk("race_prox0", c_prox[0], 1);
        chk("race_fim0", c_fim[0], 1);

        // reset while waiting for pronto, then a tie
        do_reset();
        fixed_lat = TO + 1;
        set_msg(0, 1, 7'h77, 7'h00, 7'h00);
        drive();
        for (int k = 0; k < 10 && c_part < 1; k++) tick();
        chk("rst_wait_partida", c_part, 1);
        run(3);
        do_reset();
        fixed_lat = 3;
        set_msg(0, 1, 7'h01, 7'h00, 7'h00);
        set_msg(1, 1, 7'h02, 7'h00, 7'h00);
        drive();
        run(25);
        chk("rst_tie_first_is_0", g0_first < g1_first && g0_first >= 0, 1);
        chk("rst_fim0_no_extra", c_fim[0], 1);

        // randomized traffic against the model
        do_reset();
        fixed_lat = 0;
        rnd = 1'b1;
        drive();
        run(4000);
        rnd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
